// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access controller.
//   mem_control_t  : funct3 size/sign encodings of loads and stores
//   RESULT_SRC_MEM : result-select value that marks a load
//   mem_state_t    : access FSM states
//   access_size_t  : decoded access width, plus lane helper functions
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_control_t;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } access_size_t;

    // Unused funct3 codes fall through to a word access.
    function automatic access_size_t access_size(logic [2:0] funct3);
        case (funct3)
            MEM_B, MEM_BU: return SizeByte;
            MEM_H, MEM_HU: return SizeHalf;
            default:       return SizeWord;
        endcase
    endfunction

    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] offset);
        case (access_size(funct3))
            SizeHalf: return offset[0];
            SizeWord: return |offset;
            default:  return 1'b0;
        endcase
    endfunction

    // Halves look at offset[1] only and words ignore the offset, so the
    // misaligned low bits are dropped when trapping is disabled.
    function automatic logic [3:0] lane_byte_en(logic [2:0] funct3, logic [1:0] offset);
        case (access_size(funct3))
            SizeByte: return 4'b0001 << offset;
            SizeHalf: return offset[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes; Byte_En picks the live one.
    function automatic logic [31:0] lane_w_data(logic [2:0] funct3, logic [31:0] data);
        case (access_size(funct3))
            SizeByte: return {4{data[7:0]}};
            SizeHalf: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port.
//   master : driven by mem_access_unit (Req, We, Addr, Byte_En, W_Data out;
//            R_Data, Ack in)
//   slave  : the memory side of the same signals
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              DMEM_Req;
    logic              DMEM_We;
    logic [ADDR_W-1:0] DMEM_Addr;
    logic [3:0]        DMEM_Byte_En;
    logic [31:0]       DMEM_W_Data;
    logic [31:0]       DMEM_R_Data;
    logic              DMEM_Ack;

    modport master (
        output DMEM_Req, DMEM_We, DMEM_Addr, DMEM_Byte_En, DMEM_W_Data,
        input  DMEM_R_Data, DMEM_Ack
    );

    modport slave (
        input  DMEM_Req, DMEM_We, DMEM_Addr, DMEM_Byte_En, DMEM_W_Data,
        output DMEM_R_Data, DMEM_Ack
    );
endinterface

// File: rtl/mem_access_unit_load_extender.sv
// Load lane select and sign/zero extension (purely combinational).
//   r_data_i      : read word from data memory
//   offset_i      : registered byte address bits [1:0]
//   mem_control_i : registered funct3 size/sign code
//   load_data_o   : extended load result
module mem_access_unit_load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] r_data_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  mem_control_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    always_comb begin
        byte_sel = 8'h00;
        case (offset_i)
            2'd0:    byte_sel = r_data_i[7:0];
            2'd1:    byte_sel = r_data_i[15:8];
            2'd2:    byte_sel = r_data_i[23:16];
            default: byte_sel = r_data_i[31:24];
        endcase
        half_sel = offset_i[1] ? r_data_i[31:16] : r_data_i[15:0];
        sign_ext = (mem_control_i != MEM_BU) && (mem_control_i != MEM_HU);

        case (access_size(mem_control_i))
            SizeByte: load_data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SizeHalf: load_data_o = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:  load_data_o = r_data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller. Turns the EX/MEM memory controls into one
// request/acknowledge transaction on the data-memory port, builds lane enables
// and aligned store data, extends load data and stalls the pipeline while the
// transaction is outstanding.
//
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   MEM_W_En_M        : store request
//   Result_Src_Sel_M  : result select; RESULT_SRC_MEM marks a load
//   MEM_Control_M     : funct3 size/sign
//   ALU_Out_M         : effective byte address
//   REG_R_Data2_M     : unaligned store data
//   dmem              : data-memory port (master side)
//   MEM_R_Data_M      : load register, valid from DONE onward
//   Stall_M           : freeze the upstream pipeline
//   Misaligned_M      : misaligned access flag
//
// Build option: define MISALIGN_TRAP_EN to suppress misaligned half/word
// accesses and raise Misaligned_M; otherwise offending low address bits are
// ignored and Misaligned_M is tied low.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32  // must not exceed 32
)(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MEM_W_En_M,
    input  logic [1:0]                Result_Src_Sel_M,
    input  logic [2:0]                MEM_Control_M,
    input  logic [31:0]               ALU_Out_M,
    input  logic [31:0]               REG_R_Data2_M,
    mem_access_unit_if.master         dmem,
    output logic [31:0]               MEM_R_Data_M,
    output logic                      Stall_M,
    output logic                      Misaligned_M
);

    mem_state_t        state_q, state_d;
    logic              access;
    logic              suppress;
    logic              start;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [1:0]        off_q;
    logic [2:0]        ctrl_q;
    logic [31:0]       load_q;
    logic [31:0]       load_ext;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        byte_en;
    logic [31:0]       w_data;

    // A store with the load select also set is still a store: we_q follows
    // MEM_W_En_M alone.
    assign access = MEM_W_En_M | (Result_Src_Sel_M == RESULT_SRC_MEM);

`ifdef MISALIGN_TRAP_EN
    assign suppress = access & is_misaligned(MEM_Control_M, ALU_Out_M[1:0]);
`else
    assign suppress = 1'b0;
`endif

    assign start        = (state_q == IDLE) & access & ~suppress;
    assign Misaligned_M = (state_q == IDLE) & suppress;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Ack outside BUSY is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access && !suppress) state_d = BUSY;
            BUSY:    if (dmem.DMEM_Ack)       state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. The bus is quiet outside BUSY; the IDLE stall term is
    // combinational so the access freezes the pipeline in its first cycle.
    always_comb begin
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        byte_en = 4'b0000;
        w_data  = 32'h0;
        Stall_M = 1'b0;
        case (state_q)
            IDLE: Stall_M = access & ~suppress;
            BUSY: begin
                req     = 1'b1;
                we      = we_q;
                addr    = addr_q;
                byte_en = be_q;
                w_data  = wdata_q;
                Stall_M = 1'b1;
            end
            default: ;
        endcase
    end

    assign dmem.DMEM_Req     = req;
    assign dmem.DMEM_We      = we;
    assign dmem.DMEM_Addr    = addr;
    assign dmem.DMEM_Byte_En = byte_en;
    assign dmem.DMEM_W_Data  = w_data;

    // Request register, loaded as the FSM leaves IDLE so the bus stays stable
    // for the whole BUSY phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
            ctrl_q  <= 3'b000;
        end else if (start) begin
            we_q    <= MEM_W_En_M;
            addr_q  <= {ALU_Out_M[ADDR_W-1:2], 2'b00};
            be_q    <= lane_byte_en(MEM_Control_M, ALU_Out_M[1:0]);
            wdata_q <= lane_w_data(MEM_Control_M, REG_R_Data2_M);
            off_q   <= ALU_Out_M[1:0];
            ctrl_q  <= MEM_Control_M;
        end
    end

    mem_access_unit_load_extender load_extender (
        .r_data_i      (dmem.DMEM_R_Data),
        .offset_i      (off_q),
        .mem_control_i (ctrl_q),
        .load_data_o   (load_ext)
    );

    // Load register: only a completed load updates it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_q <= 32'h0;
        end else if ((state_q == BUSY) && dmem.DMEM_Ack && !we_q) begin
            load_q <= load_ext;
        end
    end

    assign MEM_R_Data_M = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_W_En_M;
    logic [1:0]  Result_Src_Sel_M;
    logic [2:0]  MEM_Control_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] REG_R_Data2_M;
    logic [31:0] MEM_R_Data_M;
    logic        Stall_M;
    logic        Misaligned_M;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_ld = 32'h0;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) dmem ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .MEM_W_En_M       (MEM_W_En_M),
        .Result_Src_Sel_M (Result_Src_Sel_M),
        .MEM_Control_M    (MEM_Control_M),
        .ALU_Out_M        (ALU_Out_M),
        .REG_R_Data2_M    (REG_R_Data2_M),
        .dmem             (dmem),
        .MEM_R_Data_M     (MEM_R_Data_M),
        .Stall_M          (Stall_M),
        .Misaligned_M     (Misaligned_M)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Access width in bytes from the funct3 code.
    function automatic int ref_size(logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Loaded value from arithmetic on the read word.
    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        int     size;
        int     off;
        longint v;
        bit     sgn;
        size = ref_size(f3);
        if (size == 4) return rd;
        off = int'(a % 4) - int'(a % 4) % size;
        sgn = (f3 == 3'b000) || (f3 == 3'b001);
        v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * size));
        if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic clear_inputs();
        MEM_W_En_M       = 1'b0;
        Result_Src_Sel_M = 2'b00;
        MEM_Control_M    = 3'b000;
        ALU_Out_M        = 32'h0;
        REG_R_Data2_M    = 32'h0;
    endtask

    // One access, started in an IDLE cycle just after a clock edge; returns
    // in the following IDLE cycle with the inputs cleared.
    task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int waits,
                              input string tag);
        int          size;
        int          eff_off;
        int          stalls;
        int          busy;
        int          be_i;
        bit          trap;
        bit          acked;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;

        size    = ref_size(f3);
        eff_off = int'(a % 4) - int'(a % 4) % size;
        trap    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap    = (int'(a % 4) % size) != 0;
`endif
        be_i     = ((1 << size) - 1) << eff_off;
        exp_be   = be_i[3:0];
        exp_addr = a - (a % 4);
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];

        MEM_W_En_M       = st;
        Result_Src_Sel_M = st ? 2'b00 : RESULT_SRC_MEM;
        MEM_Control_M    = f3;
        ALU_Out_M        = a;
        REG_R_Data2_M    = wd;
        #1;
        checks++;
        if ({dmem.DMEM_Req, Stall_M, Misaligned_M} !== {1'b0, !trap, trap}) begin
            failures++;
            $display("FAIL %s idle req/stall/misaligned: got %b expected %b", tag,
                     {dmem.DMEM_Req, Stall_M, Misaligned_M}, {1'b0, !trap, trap});
        end

        if (trap) begin
            @(posedge CLK); #1;
            checks++;
            if ({dmem.DMEM_Req, Stall_M, MEM_R_Data_M} !== {1'b0, 1'b0, exp_ld}) begin
                failures++;
                $display("FAIL %s suppressed req/stall/load: got %b/%b/%h expected 0/0/%h",
                         tag, dmem.DMEM_Req, Stall_M, MEM_R_Data_M, exp_ld);
            end
            clear_inputs();
            #1;
            return;
        end

        stalls = Stall_M ? 1 : 0;
        busy   = 0;
        acked  = 1'b0;
        while (!acked && busy < 40) begin
            @(posedge CLK); #1;
            busy++;
            if (Stall_M) stalls++;
            checks++;
            if ({dmem.DMEM_Req, dmem.DMEM_We, dmem.DMEM_Addr, dmem.DMEM_Byte_En} !==
                {1'b1, st, exp_addr, exp_be}) begin
                failures++;
                $display("FAIL %s busy req/we/addr/be: got %b/%b/%h/%b expected 1/%b/%h/%b",
                         tag, dmem.DMEM_Req, dmem.DMEM_We, dmem.DMEM_Addr,
                         dmem.DMEM_Byte_En, st, exp_addr, exp_be);
            end
            if (st) begin
                checks++;
                if (dmem.DMEM_W_Data !== exp_wd) begin
                    failures++;
                    $display("FAIL %s w_data: got %h expected %h", tag, dmem.DMEM_W_Data,
                             exp_wd);
                end
            end
            if (dmem.DMEM_Req && busy > waits) begin
                dmem.DMEM_Ack    = 1'b1;
                dmem.DMEM_R_Data = rd;
                acked            = 1'b1;
            end else begin
                dmem.DMEM_Ack    = 1'b0;
                dmem.DMEM_R_Data = $urandom;
            end
        end
        if (!acked) begin
            checks++;
            failures++;
            $display("FAIL %s ack timeout: req never held for %0d cycles", tag, waits + 1);
        end

        @(posedge CLK); #1;
        dmem.DMEM_Ack = 1'b0;
        if (!st) exp_ld = ref_load(f3, a, rd);
        checks++;
        if ({dmem.DMEM_Req, Stall_M} !== 2'b00) begin
            failures++;
            $display("FAIL %s done req/stall: got %b expected 00", tag,
                     {dmem.DMEM_Req, Stall_M});
        end
        checks++;
        if (stalls !== waits + 2) begin
            failures++;
            $display("FAIL %s stall cycles: got %0d expected %0d", tag, stalls, waits + 2);
        end
        checks++;
        if (MEM_R_Data_M !== exp_ld) begin
            failures++;
            $display("FAIL %s load data: got %h expected %h", tag, MEM_R_Data_M, exp_ld);
        end

        @(posedge CLK); #1;
        clear_inputs();
        #1;
        checks++;
        if ({dmem.DMEM_Req, Stall_M} !== 2'b00) begin
            failures++;
            $display("FAIL %s gap req/stall: got %b expected 00", tag,
                     {dmem.DMEM_Req, Stall_M});
        end
    endtask

    task automatic test_reset();
        RST              = 1'b1;
        dmem.DMEM_Ack    = 1'b0;
        dmem.DMEM_R_Data = 32'h0;
        clear_inputs();
        #1;
        checks++;
        if ({dmem.DMEM_Req, dmem.DMEM_We, dmem.DMEM_Byte_En, dmem.DMEM_Addr, dmem.DMEM_W_Data,
             MEM_R_Data_M, Misaligned_M, Stall_M} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got req=%b we=%b be=%b addr=%h wd=%h ld=%h mis=%b st=%b expected all 0",
                     dmem.DMEM_Req, dmem.DMEM_We, dmem.DMEM_Byte_En, dmem.DMEM_Addr,
                     dmem.DMEM_W_Data, MEM_R_Data_M, Misaligned_M, Stall_M);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        checks++;
        if ({dmem.DMEM_Req, Stall_M} !== 2'b00) begin
            failures++;
            $display("FAIL non-access idle: got %b expected 00", {dmem.DMEM_Req, Stall_M});
        end
    endtask

    task automatic test_directed();
        run_access(1'b1, MEM_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, "sw");
        run_access(1'b1, MEM_B,  32'h103, 32'h000000A5, 32'h0,        0, "sb");
        run_access(1'b0, MEM_B,  32'h101, 32'h0,        32'h00008000, 3, "lb");
        run_access(1'b0, MEM_BU, 32'h101, 32'h0,        32'h00008000, 3, "lbu");
        run_access(1'b0, MEM_H,  32'h102, 32'h0,        32'h80010000, 1, "lh");
        run_access(1'b0, MEM_HU, 32'h102, 32'h0,        32'h80010000, 0, "lhu");
        run_access(1'b1, MEM_H,  32'h202, 32'h1234BEEF, 32'h0,        2, "sh");
    endtask

    task automatic test_reset_mid_busy();
        MEM_W_En_M       = 1'b0;
        Result_Src_Sel_M = RESULT_SRC_MEM;
        MEM_Control_M    = MEM_W;
        ALU_Out_M        = 32'h300;
        #1;
        @(posedge CLK); #1;
        checks++;
        if (dmem.DMEM_Req !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy req before reset: got %b expected 1", dmem.DMEM_Req);
        end
        RST              = 1'b1;
        dmem.DMEM_Ack    = 1'b1;
        dmem.DMEM_R_Data = 32'h12345678;
        #1;
        checks++;
        if (dmem.DMEM_Req !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy req drop: got %b expected 0", dmem.DMEM_Req);
        end
        clear_inputs();
        exp_ld = 32'h0;
        #1;
        checks++;
        if ({Stall_M, MEM_R_Data_M} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL rst_busy stall/load: got %b/%h expected 0/00000000", Stall_M,
                     MEM_R_Data_M);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        dmem.DMEM_Ack = 1'b0;
        checks++;
        if ({dmem.DMEM_Req, MEM_R_Data_M} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL rst_busy after release req/load: got %b/%h expected 0/00000000",
                     dmem.DMEM_Req, MEM_R_Data_M);
        end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, MEM_W, 32'h102, 32'h0, 32'hCAFEF00D, 0, "lw_mis");
        run_access(1'b1, MEM_H, 32'h105, 32'h0000ABCD, 32'h0, 0, "sh_mis");
        run_access(1'b0, MEM_H, 32'h107, 32'h0, 32'h9ABC0000, 1, "lh_mis");
    endtask

    task automatic test_ack_in_idle();
        dmem.DMEM_Ack    = 1'b1;
        dmem.DMEM_R_Data = 32'h5A5A5A5A;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            checks++;
            if ({dmem.DMEM_Req, Stall_M, MEM_R_Data_M} !== {2'b00, exp_ld}) begin
                failures++;
                $display("FAIL ack_idle req/stall/load: got %b/%b/%h expected 0/0/%h",
                         dmem.DMEM_Req, Stall_M, MEM_R_Data_M, exp_ld);
            end
        end
        dmem.DMEM_Ack = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] f3;
        bit         st;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = f3s[$urandom_range(0, 4)];
            if (st) f3 = {1'b0, f3[1:0]};
            run_access(st, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                       "rand");
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, MEM_B,  32'h400, 32'h0,        32'h000000FF, 0, "b2b_lb");
        run_access(1'b1, MEM_W,  32'h404, 32'h01020304, 32'h0,        0, "b2b_sw");
        run_access(1'b0, MEM_HU, 32'h406, 32'h0,        32'hF00D0000, 0, "b2b_lhu");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_busy();
        test_directed();
        test_misaligned();
        test_ack_in_idle();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
